// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target-side write receiver.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam logic [I2C_ADDR_W-1:0] I2C_GENERAL_CALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for one bus pin, followed by a registered edge detector.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle bus level so leaving reset never fakes a START/STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= pin;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl  = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target write receiver: address match, byte shift-in, ACK drive, valid/ready output.
// Optional macro I2C_GENERAL_CALL_EN also acknowledges the general-call address (7'h00, write).
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting address + R/W
// ADDR_ACK | pulling SDA low through the address ACK pulse
// DATA     | shifting a data byte
// DATA_ACK | pulling SDA low through the data ACK pulse
// IGNORE   | not addressed or NACKed; wait for START/STOP
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter int                      N           = 8,
    parameter logic [I2C_ADDR_W-1:0]   DEVICE_ADDR = 7'h42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         scl_i,
    input  logic         sda_i,
    output logic         sda_oe,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         busy,
    output logic         stop_det,
    output logic         overrun
);

    localparam int               CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (scl_i),
        .lvl  (scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (sda_i),
        .lvl  (sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    i2c_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [N-1:0]     shift_q, shift_d;
    logic             sda_oe_d, busy_d, stop_d, overrun_d, load;
    logic             start_evt, stop_evt, addr_hit, buf_free;

    assign start_evt = scl_lvl & sda_fall;
    assign stop_evt  = scl_lvl & sda_rise;
    assign buf_free  = ~rx_valid | rx_ready;

`ifdef I2C_GENERAL_CALL_EN
    assign addr_hit = (shift_q[N-1 -: I2C_ADDR_W] == DEVICE_ADDR) ||
                      (shift_q[N-1 -: I2C_ADDR_W] == I2C_GENERAL_CALL_ADDR);
`else
    assign addr_hit = (shift_q[N-1 -: I2C_ADDR_W] == DEVICE_ADDR);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            stop_det  <= 1'b0;
            overrun   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
            stop_det  <= stop_d;
            overrun   <= overrun_d;
            if (load) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sda_oe_d  = sda_oe;
        busy_d    = busy;
        stop_d    = 1'b0;
        overrun_d = 1'b0;
        load      = 1'b0;

        if (stop_evt) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            stop_d    = 1'b1;
        end else if (start_evt) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            shift_d   = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, IGNORE: begin
                end
                ADDR: begin
                    if (scl_rise && bit_cnt_q != CNT_FULL) begin
                        shift_d   = {shift_q[N-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == CNT_FULL) begin
                        bit_cnt_d = '0;
                        // shift_q[0] is R/W; reads are never acknowledged
                        if (addr_hit && !shift_q[0]) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise && bit_cnt_q != CNT_FULL) begin
                        shift_d   = {shift_q[N-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == CNT_FULL) begin
                        bit_cnt_d = '0;
                        if (buf_free) begin
                            load     = 1'b1;
                            sda_oe_d = 1'b1;
                            state_d  = DATA_ACK;
                        end else begin
                            overrun_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = IGNORE;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // first falling edge seen here closes the 9th pulse
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: directed and random write transactions against a transaction-level model.
module tb_i2c_target_rx;

    localparam int Q = 10;
`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       rx_ready = 1'b0;
    logic       scl_i, sda_i;
    logic       sda_oe, rx_valid, busy, stop_det, overrun;
    logic [7:0] rx_data;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_rx #(.N(8), .DEVICE_ADDR(7'h42)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .stop_det (stop_det),
        .overrun  (overrun)
    );

    int         total = 0;
    int         bad = 0;
    int         stop_seen = 0;
    int         ovr_seen = 0;
    int         oe_viol = 0;
    logic       oe_prev = 1'b0;
    int         exp_stops = 0;
    int         exp_ovr = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;

    always @(negedge clk) begin
        if (stop_det === 1'b1) stop_seen++;
        if (overrun === 1'b1) ovr_seen++;
        if (sda_oe !== oe_prev && m_scl === 1'b1) oe_viol++;
        oe_prev = sda_oe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wclk(Q); m_sda = 1'b1;
        wclk(Q); m_scl = 1'b1;
        wclk(Q); m_sda = 1'b0;
        wclk(Q); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wclk(Q); m_sda = 1'b0;
        wclk(Q); m_scl = 1'b1;
        wclk(Q); m_sda = 1'b1;
        wclk(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            wclk(Q); m_sda = b[i];
            wclk(Q); m_scl = 1'b1;
            wclk(2 * Q); m_scl = 1'b0;
        end
    endtask

    task automatic ack_bit(output logic ack);
        wclk(Q); m_sda = 1'b1;
        wclk(Q); m_scl = 1'b1;
        wclk(Q); ack = sda_oe;
        wclk(Q); m_scl = 1'b0;
        wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        ack_bit(ack);
    endtask

    function automatic logic addr_ok(input logic [6:0] a, input logic rw);
        return !rw && (a == 7'h42 || (GC && a == 7'h00));
    endfunction

    task automatic consume();
        rx_ready = 1'b1;
        check("consume_pre_valid", rx_valid, 1);
        wclk(1);
        check("consume_post_valid", rx_valid, 0);
        rx_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

    // Full write transaction: START, address, data bytes until the first NACK, STOP.
    task automatic xact(input logic [6:0] a, input logic rw, input logic [7:0] dq[$], input string tag);
        logic ack;
        logic live;
        logic exp_ack;
        bus_start();
        send_byte({a, rw}, ack);
        live = addr_ok(a, rw);
        check({tag, "_addr_ack"}, ack, live);
        check({tag, "_busy_addr"}, busy, live);
        foreach (dq[i]) begin
            send_byte(dq[i], ack);
            exp_ack = live && !exp_valid;
            if (exp_ack) begin
                exp_valid = 1'b1;
                exp_data  = dq[i];
            end else if (live) begin
                exp_ovr++;
            end
            check({tag, "_data_ack"}, ack, exp_ack);
            check({tag, "_rx_data"}, rx_data, exp_data);
            check({tag, "_rx_valid"}, rx_valid, exp_valid);
            if (!exp_ack) break;
            check({tag, "_busy_data"}, busy, 1);
        end
        bus_stop();
        exp_stops++;
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_stop_cnt"}, stop_seen, exp_stops);
        check({tag, "_ovr_cnt"}, ovr_seen, exp_ovr);
    endtask

    initial begin
        logic [7:0] dq[$];
        logic       ack;
        logic       got;
        logic [6:0] a;

        wclk(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stop_det", stop_det, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;
        wclk(5);

        dq = {8'hA5};
        xact(7'h42, 1'b0, dq, "basic");
        wclk(5);
        check("basic_hold_valid", rx_valid, 1);
        check("basic_hold_data", rx_data, 8'hA5);
        consume();

        dq = {8'hFF};
        xact(7'h43, 1'b0, dq, "wrong_addr");

        dq = {8'h5A};
        xact(7'h42, 1'b1, dq, "read");

        dq = {8'h11, 8'h22};
        xact(7'h42, 1'b0, dq, "overrun");
        check("overrun_keep_data", rx_data, 8'h11);
        consume();

        // repeated START in the middle of a data byte
        bus_start();
        send_byte(8'h84, ack);
        check("rs_addr1_ack", ack, 1);
        send_bits(8'hC3, 4);
        bus_start();
        send_byte(8'h84, ack);
        check("rs_addr2_ack", ack, 1);
        send_byte(8'h3C, ack);
        check("rs_data_ack", ack, 1);
        bus_stop();
        exp_stops++;
        exp_valid = 1'b1;
        exp_data  = 8'h3C;
        check("rs_rx_data", rx_data, exp_data);
        check("rs_rx_valid", rx_valid, 1);
        check("rs_stop_cnt", stop_seen, exp_stops);
        consume();

        dq = {8'h77};
        xact(7'h00, 1'b0, dq, "gen_call");
        if (exp_valid) consume();

        // reset asserted while the address ACK is being driven
        bus_start();
        send_bits(8'h84, 8);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            wclk(1);
            got = sda_oe;
        end
        check("rst_ack_asserted", got, 1);
        check("rst_ack_busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_sda_oe", sda_oe, 0);
        check("rst_mid_busy", busy, 0);
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        wclk(2);
        rst = 1'b1;
        ack_bit(ack);
        check("rst_mid_no_ack", ack, 0);
        bus_stop();
        exp_stops++;
        check("rst_mid_stop_cnt", stop_seen, exp_stops);

        for (int it = 0; it < 10; it++) begin
            if (exp_valid && $urandom_range(0, 1) == 1) consume();
            case ($urandom_range(0, 3))
                0:       a = 7'h42;
                1:       a = 7'h00;
                default: a = 7'($urandom_range(0, 127));
            endcase
            dq = {};
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) dq.push_back(8'($urandom));
            xact(a, ($urandom_range(0, 3) == 0), dq, $sformatf("rnd%0d", it));
        end

        check("final_stop_cnt", stop_seen, exp_stops);
        check("final_ovr_cnt", ovr_seen, exp_ovr);
        check("oe_change_while_scl_high", oe_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target-side (responder) write receiver; counterpart to the initiator-side shift/drive datapath in the I2C design.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Shifts in the address byte and data bytes MSB-first and drives ACK/NACK through an open-drain enable.
- Hands each accepted data byte to core logic on a valid/ready handshake.

Parameters:
- N, 8, data byte width (fixed at 8 for I2C; kept for datapath consistency).
- DEVICE_ADDR, 7'h42, 7-bit target address this block answers to.

Ports:
- clk  input  1  system clock; must be ≥8× the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL pin level.
- sda_i  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  output  N  last accepted data byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts; byte consumed when rx_valid && rx_ready.
- busy  output  1  high from an address match until STOP or NACK.
- stop_det  output  1  one-clk pulse on each detected STOP.
- overrun  output  1  one-clk pulse when a byte is NACKed because the buffer is full.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, bit counter 0, shift register 0.
  - Outputs: sda_oe=0, rx_data=0, rx_valid=0, busy=0, stop_det=0, overrun=0.
  - Reset mid-transaction releases SDA immediately.
- Input path: scl_i and sda_i each pass through a 2-flop synchroniser, then a registered edge detector.
  - Bus events act 3 clk after the pin change.
- Events on the synchronised signals:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - Data bits are sampled on SCL rising edges.
- STOP in any state: go to IDLE, pulse stop_det, clear busy, set sda_oe=0. rx_valid and rx_data are unaffected.
- START in any state (including repeated START mid-byte): go to ADDR and clear the bit counter. The partial byte is discarded.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits; the 8th is R/W. At the SCL falling edge after bit 8:
    - If addr==DEVICE_ADDR and R/W=0: sda_oe=1, busy=1, go to ADDR_ACK.
    - Otherwise go to IGNORE with sda_oe=0. Reads are never acknowledged.
  - ADDR_ACK: hold sda_oe=1 through the 9th SCL pulse; release at its falling edge; go to DATA.
  - DATA: shift 8 bits. At the SCL falling edge after bit 8:
    - If buffer free (rx_valid=0, or rx_valid && rx_ready this clk): load rx_data, set rx_valid next clk, sda_oe=1, go to DATA_ACK.
    - Otherwise: sda_oe=0, pulse overrun, clear busy, go to IGNORE. rx_data is unchanged.
  - DATA_ACK: hold ACK through the 9th pulse; release at its falling edge; go to DATA.
  - IGNORE: drive nothing; wait for START or STOP.
- Handshake: rx_valid clears on the clk after rx_valid && rx_ready. It is never cleared by bus activity.
  - Simultaneous consume and load: the new byte wins and rx_valid stays 1.
- sda_oe changes only while SCL is low, on the synchronised SCL falling edge.

Optional Feature:
- Macro: I2C_GENERAL_CALL_EN.
- Defined: address 7'h00 with W is also ACKed, and its data bytes are received exactly as for DEVICE_ADDR.
- Undefined: 7'h00 is treated as a non-matching address (IGNORE, no ACK).

Decomposition:
- Package i2c_pkg holds:
  - the state enum typedef (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE);
  - the constants I2C_ADDR_W=7 and I2C_GENERAL_CALL_ADDR=7'h00.
- Sub-module i2c_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs, instantiated once for SCL and once for SDA.

Test Plan:
- START, 0x84 (addr 0x42 W), 0xA5, STOP → both addresses and data ACKed (sda_oe=1 in each 9th pulse); rx_data=0xA5, rx_valid=1 until rx_ready; stop_det one-clk pulse; busy 1→0.
- START, 0x86 (addr 0x43 W), 0xFF, STOP → sda_oe stays 0 throughout; rx_valid stays 0; busy stays 0.
- START, 0x85 (addr 0x42 R) → NACK (sda_oe=0 in the 9th pulse); state IGNORE until STOP.
- Addr 0x42 W, then 0x11, 0x22 with rx_ready=0 → 0x11 ACKed, 0x22 NACKed; overrun pulses once; rx_data stays 0x11; raising rx_ready clears rx_valid the next clk.
- Repeated START after 4 data bits, then 0x84, 0x3C, STOP → partial byte discarded; rx_data=0x3C.
- rst low during ADDR_ACK → sda_oe=0 and busy=0 asynchronously. With I2C_GENERAL_CALL_EN, 0x00 W is ACKed; without it, NACKed.
